// File: rtl/mem_pkg.sv
// Shared types, widths and the byte-merge helper for the BRAM request front end.
package mem_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } mem_state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BE_W-1:0]   be_t;

    // Enabled bytes come from the new write data, the rest from the old word.
    function automatic data_t byte_merge(input data_t wdata, input data_t rdata, input be_t be);
        data_t merged;
        for (int unsigned i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// In-order response buffer; lane a is older than lane b when both push together.
module rsp_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_a_i,
    input  data_t                        data_a_i,
    input  logic                         push_b_i,
    input  data_t                        data_b_i,
    input  logic                         pop_i,
    output data_t                        rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    data_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr_b;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_b = push_a_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        wr_ptr_d = push_b_i ? ptr_inc(wr_ptr_b) : wr_ptr_b;
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push_a_i) mem_q[wr_ptr_q] <= data_a_i;
        if (push_b_i) mem_q[wr_ptr_b] <= data_b_i;
    end

    assign rdata_o = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/mem_ctrl.sv
// Valid/ready front end for a single-port BRAM with read latency absorption and RMW byte writes.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [BE_W-1:0]   req_be_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_d_o,
    input  logic [DATA_W-1:0] bram_d_i
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned LVL_W = CNT_W + 1;

    mem_state_t       state_q, state_d;
    logic             rd_pend_q, rd_pend_d;
    addr_t            rmw_addr_q, rmw_addr_d;
    data_t            rmw_wdata_q, rmw_wdata_d;
    be_t              rmw_be_q, rmw_be_d;
    logic [CNT_W-1:0] occ;
    logic [LVL_W-1:0] level;
    logic             pop, ready_raw, accept, be_full, be_zero;
    logic             push_rd, push_wr;
    data_t            merged;

    // Space check counts the read still in flight so its data always has a slot.
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign level       = LVL_W'(occ) + LVL_W'(rd_pend_q) - LVL_W'(pop);
    assign ready_raw   = (state_q == S_IDLE) && (level < LVL_W'(RSP_DEPTH));
    assign req_ready_o = rst_ni & ready_raw;
    assign accept      = req_valid_i & ready_raw;
    assign be_full     = (req_be_i == '1);
    assign be_zero     = (req_be_i == '0);
    assign merged      = byte_merge(rmw_wdata_q, bram_d_i, rmw_be_q);
    assign rsp_valid_o = (occ != '0);

    // Next state and response pushes; reset holds the flops so no gating is needed here.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = 1'b0;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_be_d    = rmw_be_q;
        push_rd     = rd_pend_q;
        push_wr     = 1'b0;
        if (state_q == S_RMW) begin
            push_wr = 1'b1;
            state_d = S_IDLE;
        end else if (accept) begin
            if (!req_we_i) begin
                rd_pend_d = 1'b1;
            end else if (be_full || be_zero) begin
                push_wr = 1'b1;
            end else begin
                state_d     = S_RMW;
                rmw_addr_d  = req_addr_i;
                rmw_wdata_d = req_wdata_i;
                rmw_be_d    = req_be_i;
            end
        end
    end

    // BRAM pins are live only in an accept or RMW cycle and forced quiet under reset.
    always_comb begin
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_d_o    = '0;
        if (rst_ni) begin
            if (state_q == S_RMW) begin
                bram_en_o   = 1'b1;
                bram_we_o   = 1'b1;
                bram_addr_o = rmw_addr_q;
                bram_d_o    = merged;
            end else if (accept && !(req_we_i && be_zero)) begin
                bram_en_o   = 1'b1;
                bram_addr_o = req_addr_i;
                if (req_we_i && be_full) begin
                    bram_we_o = 1'b1;
                    bram_d_o  = req_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            rd_pend_q   <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_be_q    <= rmw_be_d;
        end
    end

    rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_a_i (push_rd),
        .data_a_i (bram_d_i),
        .push_b_i (push_wr),
        .data_b_i ('0),
        .pop_i    (pop),
        .rdata_o  (rsp_rdata_o),
        .count_o  (occ)
    );

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Request/response front end for the 32-bit single-port block RAM. It accepts word requests on a valid/ready channel, drives the BRAM enable/write/address/data pins, and absorbs the BRAM's one-cycle registered read latency. It performs read-modify-write for partial byte-enable writes and returns exactly one in-order response per request through a 2-entry response buffer. It sits between the core's load/store path (upstream) and the BRAM (downstream).

## Interface
- ADDR_W, 14, word address width (matches BRAM).
- DATA_W, 32, data width; BE_W = DATA_W/8 is derived, not overridable.
- RSP_DEPTH, 2, response buffer entries.

- clk_i  in  1  rising-edge clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_be_i  in  BE_W  byte enables (writes only; ignored on reads).
- req_addr_i  in  ADDR_W  word address.
- req_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_rdata_o  out  DATA_W  read data; 0 for write responses.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  1  BRAM write enable.
- bram_addr_o  out  ADDR_W  BRAM address.
- bram_d_o  out  DATA_W  BRAM write data.
- bram_d_i  in  DATA_W  BRAM read data, valid one cycle after enable; read-first on writes.

## Operation
- States: S_IDLE, S_RMW. Separate flag rd_pend marks a BRAM read whose data arrives next cycle.
- Read, accepted in S_IDLE in cycle A: bram_en_o=1, we=0, addr=req_addr_i, driven combinationally in A. bram_d_i is captured into the response buffer at the end of A+1.
- Full write (be=all ones): bram_en_o=bram_we_o=1 in A, bram_d_o=req_wdata_i. The response (rdata=0) is pushed at the end of A.
- Partial write (be≠0, ≠all ones): A issues a read; address, wdata and be are latched; go to S_RMW.
  - In S_RMW (A+1), per byte: merged = be[i] ? wdata byte : bram_d_i byte. Issue the write with en=we=1. Push the response at the end of A+1, then return to S_IDLE.
- Write with be=0: no BRAM access; the response is pushed at the end of A.
- req_ready_o = rst_ni & (state==S_IDLE) & (occ + rd_pend − pop) < RSP_DEPTH, where pop = rsp_valid_o & rsp_ready_i. This is a combinational path from rsp_ready_i by design.
- Responses leave in acceptance order. rsp_valid_o = buffer non-empty. A simultaneous push and pop when full or empty is legal.
- Outside an accept or S_RMW cycle, all bram_* outputs are 0.

## Timing
- Read latency: accept in cycle A → rsp_valid_o first high in A+2.
- Full write: accept in A → rsp_valid_o high in A+1.
- Read and full-write throughput: 1 per cycle with rsp_ready_i held high.
- Partial-write throughput: 1 per 2 cycles. req_ready_o is low in A+1.
- Read-after-write to the same address, back-to-back: returns the new data, because the BRAM write commits at the end of A.
- Under back-pressure, the buffer fills to 2 and req_ready_o drops. Nothing is dropped or overwritten.
- Reset (async, any cycle), while rst_ni is low:
  - state=S_IDLE, rd_pend=0, buffer emptied.
  - rsp_valid_o=0, rsp_rdata_o=0, req_ready_o=0.
  - bram_en_o=bram_we_o=0, bram_addr_o=0, bram_d_o=0.
- An RMW interrupted by reset issues no write. In-flight responses are discarded.

## Structure
- Package mem_pkg holds:
  - ADDR_W, DATA_W, BE_W constants.
  - typedef mem_state_t {S_IDLE, S_RMW}.
  - typedefs for addr_t, data_t, be_t.
- Sub-module rsp_fifo: RSP_DEPTH-entry synchronous FIFO with push, pop, occupancy count, and async active-low reset.
- The byte-merge function lives in mem_pkg.

## Test plan
- Write 0xDEADBEEF to 0x0010 with be=0xF, then read 0x0010 → write response rdata=0 one cycle after accept; read response 0xDEADBEEF two cycles after accept.
- Preload 0x0020=0x11223344, write 0xAABBCCDD with be=0x5 → BRAM written with 0x11BB33DD in the cycle after accept; req_ready_o low that cycle; readback returns 0x11BB33DD.
- 8 back-to-back reads of 0x0000–0x0007 with rsp_ready_i=1 → one accept per cycle; responses in order at 2-cycle latency.
- rsp_ready_i=0, issue 4 reads → only 2 accepted, then req_ready_o=0. Raise rsp_ready_i → the remaining 2 are accepted; all 4 responses arrive in order, none lost.
- Write with be=0 → bram_en_o stays 0; response rdata=0; memory unchanged.
- Assert rst_ni low during S_RMW → no BRAM write; all outputs 0 while in reset. After release, req_ready_o=1 and the buffer is empty.
